// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - size codes carried on CSize/DSize
//   - owner IDs stored in the issue slot
//   - byte-enable constants and helpers for alignment / lane decode
package dm_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // The reserved size code 2'b11 is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    if (misaligned(size, addr_lo)) return BE_NONE;
    case (size)
      SZ_BYTE: return BE_BYTE << addr_lo;
      SZ_HALF: return addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      SZ_WORD: return BE_WORD;
      default: return BE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Extracts the addressed byte/half/word lane from a memory read word and
// sign- or zero-extends it to 32 bits.
//   rdata_i   : word read from memory
//   size_i    : access size code
//   addr_lo_i : byte offset within the word
//   uns_i     : 1 = zero-extend, 0 = sign-extend
//   data_o    : extended result
module dm_load_extend
  import dm_arb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{~uns_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the DMA/debug loader. One winner per
// cycle is registered into the issue slot, which drives the memory in the
// following cycle together with a one-cycle Ack to the owner.
//   Clock, Reset          : clock, async active-low reset
//   C*/D* request fields  : Req, We, Size, Uns, Addr, WData (CPc on CPU only)
//   CAck/CErr/CRData      : CPU completion, error and extended load data
//   DAck/DErr/DRData      : DMA completion, error and extended load data
//   MemWrite/BE/MAddr/MWData/MPc : memory drive from the issue slot
//   MRData                : combinational memory read word at MAddr
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CReq,
  input  logic        CWe,
  input  logic [1:0]  CSize,
  input  logic        CUns,
  input  logic [31:0] CAddr,
  input  logic [31:0] CWData,
  input  logic [31:0] CPc,
  output logic        CAck,
  output logic        CErr,
  output logic [31:0] CRData,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [1:0]  DSize,
  input  logic        DUns,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DAck,
  output logic        DErr,
  output logic [31:0] DRData,
  output logic        MemWrite,
  output logic [3:0]  BE,
  output logic [31:0] MAddr,
  output logic [31:0] MWData,
  output logic [31:0] MPc,
  input  logic [31:0] MRData
);

  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

  logic        valid_q, valid_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

  logic c_ack, d_ack, c_elig, d_elig, c_win, d_win, rd_ok;
  logic [31:0] ld_data;

  // A requester being Acked this cycle is still holding its old request.
  assign c_ack  = valid_q & (owner_q == OWN_CPU);
  assign d_ack  = valid_q & (owner_q == OWN_DMA);
  assign c_elig = CReq & ~c_ack;
  assign d_elig = DReq & ~d_ack;
  assign d_win  = d_elig & (~c_elig | (wait_cnt_q == StarveMax));
  assign c_win  = c_elig & ~d_win;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!DReq || d_win) begin
      wait_cnt_d = '0;
    end else if (d_elig && (wait_cnt_q != StarveMax)) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    owner_d = OWN_CPU;
    we_d    = 1'b0;
    size_d  = SZ_BYTE;
    uns_d   = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    pc_d    = '0;
    if (c_win) begin
      valid_d = 1'b1;
      owner_d = OWN_CPU;
      we_d    = CWe;
      size_d  = CSize;
      uns_d   = CUns;
      addr_d  = CAddr;
      wdata_d = CWData;
      pc_d    = CPc;
    end else if (d_win) begin
      valid_d = 1'b1;
      owner_d = OWN_DMA;
      we_d    = DWe;
      size_d  = DSize;
      uns_d   = DUns;
      addr_d  = DAddr;
      wdata_d = DWData;
    end
    be_d  = valid_d ? byte_enables(size_d, addr_d[1:0]) : BE_NONE;
    err_d = valid_d & misaligned(size_d, addr_d[1:0]);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      valid_q    <= 1'b0;
      owner_q    <= OWN_CPU;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      be_q       <= BE_NONE;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      be_q       <= be_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  dm_load_extend u_load_extend (
    .rdata_i   (MRData),
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .uns_i     (uns_q),
    .data_o    (ld_data)
  );

  assign rd_ok    = ~we_q & ~err_q;
  assign CAck     = c_ack;
  assign CErr     = c_ack & err_q;
  assign CRData   = (c_ack & rd_ok) ? ld_data : '0;
  assign DAck     = d_ack;
  assign DErr     = d_ack & err_q;
  assign DRData   = (d_ack & rd_ok) ? ld_data : '0;
  assign MemWrite = valid_q & we_q & ~err_q;
  assign BE       = be_q;
  assign MAddr    = addr_q;
  assign MWData   = wdata_q;
  assign MPc      = pc_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic [1:0]  req, we, uns;
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] cpc;
  logic        c_ack, d_ack, c_err, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [1:0]  ack, err;
  logic [31:0] rdata [2];
  logic        MemWrite;
  logic [3:0]  BE;
  logic [31:0] MAddr, MWData, MPc, MRData;

  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  int vectors = 0;
  int miscompares = 0;

  assign ack = {d_ack, c_ack};
  assign err = {d_err, c_err};
  assign rdata[0] = c_rdata;
  assign rdata[1] = d_rdata;

  dm_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .CReq(req[0]), .CWe(we[0]), .CSize(size[0]), .CUns(uns[0]), .CAddr(addr[0]),
    .CWData(wdata[0]), .CPc(cpc), .CAck(c_ack), .CErr(c_err), .CRData(c_rdata),
    .DReq(req[1]), .DWe(we[1]), .DSize(size[1]), .DUns(uns[1]), .DAddr(addr[1]),
    .DWData(wdata[1]), .DAck(d_ack), .DErr(d_err), .DRData(d_rdata),
    .MemWrite(MemWrite), .BE(BE), .MAddr(MAddr), .MWData(MWData), .MPc(MPc),
    .MRData(MRData)
  );

  // Word-wide memory: store data arrives low-aligned, so lane i takes the
  // byte at offset (i - addr[1:0]) of MWData.
  assign MRData = mem[MAddr[7:2]];
  always @(posedge Clock) begin
    if (MemWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) begin
          int off;
          off = i - int'(MAddr[1:0]);
          if (off < 0) off = 0;
          mem[MAddr[7:2]][8*i +: 8] <= MWData[8*off +: 8];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int lanes;
    if (is_mis(sz, a)) return 4'd0;
    lanes = (1 << nbytes(sz)) - 1;
    return 4'(lanes << a[1:0]);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a);
    logic [63:0] v, mask;
    int n;
    n = nbytes(sz);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(ref_mem[(a + k) & 255]) << (8 * k));
    mask = (64'd1 << (8 * n)) - 64'd1;
    if (!u && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < nbytes(sz); k++) ref_mem[(a + k) & 255] = wd[8*k +: 8];
  endtask

  // Single-requester access; returns what was seen in the Ack cycle.
  task automatic access(input int p, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic got, output logic e, output logic [31:0] rd,
                        output logic mw, output logic [3:0] be_o);
    we[p] = w; size[p] = sz; uns[p] = u; addr[p] = a; wdata[p] = wd;
    if (p == 0) cpc = 32'h0000_4000 + a;
    req[p] = 1'b1;
    got = 1'b0; e = 1'b0; rd = '0; mw = 1'b0; be_o = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge Clock); #1;
      if (ack[p]) begin
        got = 1'b1; e = err[p]; rd = rdata[p]; mw = MemWrite; be_o = BE;
      end
    end
    @(posedge Clock); #1;
    req[p] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    req = 2'b11;
    repeat (2) @(posedge Clock);
    #1;
    vectors++;
    if (ack !== 2'b00 || err !== 2'b00) begin
      miscompares++; $display("FAIL reset_ack: got ack=%b err=%b, expected 00/00", ack, err);
    end
    vectors++;
    if (MemWrite !== 1'b0 || BE !== 4'h0) begin
      miscompares++; $display("FAIL reset_mem: got MemWrite=%b BE=%h, expected 0/0", MemWrite, BE);
    end
    vectors++;
    if (MAddr !== 32'd0 || MWData !== 32'd0 || MPc !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got MAddr=%h MWData=%h MPc=%h, expected 0", MAddr, MWData, MPc);
    end
    vectors++;
    if (c_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      miscompares++; $display("FAIL reset_rdata: got %h/%h, expected 0", c_rdata, d_rdata);
    end
    vectors++;
    if (dut.wait_cnt_q !== 3'd0) begin
      miscompares++; $display("FAIL reset_wait_cnt: got %0d, expected 0", dut.wait_cnt_q);
    end
    req = 2'b00;
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_word();
    logic g, e, mw; logic [31:0] rd; logic [3:0] be;
    access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, g, e, rd, mw, be);
    vectors++;
    if ({g, e, mw, be} !== {1'b1, 1'b0, 1'b1, 4'hF}) begin
      miscompares++; $display("FAIL word_store: got ack=%b err=%b mw=%b be=%h, expected 1/0/1/f",
                              g, e, mw, be);
    end
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, g, e, rd, mw, be);
    vectors++;
    if (rd !== 32'h1234_5678 || mw !== 1'b0) begin
      miscompares++; $display("FAIL word_load: got %h mw=%b, expected 12345678 mw=0", rd, mw);
    end
  endtask

  task automatic test_byte();
    logic g, e, mw; logic [31:0] rd; logic [3:0] be;
    access(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB, g, e, rd, mw, be);
    vectors++;
    if (be !== 4'b1000 || mw !== 1'b1 || e !== 1'b0) begin
      miscompares++; $display("FAIL byte_store_be: got be=%b mw=%b, expected 1000 mw=1", be, mw);
    end
    access(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, g, e, rd, mw, be);
    vectors++;
    if (rd !== 32'hFFFF_FFAB) begin
      miscompares++; $display("FAIL byte_load_signed: got %h, expected ffffffab", rd);
    end
    access(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, g, e, rd, mw, be);
    vectors++;
    if (rd !== 32'h0000_00AB) begin
      miscompares++; $display("FAIL byte_load_unsigned: got %h, expected 000000ab", rd);
    end
  endtask

  task automatic test_misaligned();
    logic g, e, mw; logic [31:0] rd; logic [3:0] be;
    access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, g, e, rd, mw, be);
    access(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_5555, g, e, rd, mw, be);
    vectors++;
    if ({g, e, mw, be, rd} !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h0}) begin
      miscompares++; $display("FAIL misaligned_half: got ack=%b err=%b mw=%b be=%h rd=%h, expected 1/1/0/0/0",
                              g, e, mw, be, rd);
    end
    access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, g, e, rd, mw, be);
    vectors++;
    if (rd !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL misaligned_unchanged: got %h, expected cafef00d", rd);
    end
  endtask

  task automatic test_starvation();
    int first;
    first = 0;
    we = 2'b00; size[0] = 2'd2; size[1] = 2'd2; uns = 2'b00;
    addr[0] = 32'h40; addr[1] = 32'h44; cpc = 32'h100;
    req = 2'b11;
    for (int c = 1; c <= 8 && first == 0; c++) begin
      @(posedge Clock); #1;
      if (ack[1]) first = c;
    end
    vectors++;
    if (first == 0 || first > 6) begin
      miscompares++; $display("FAIL starve_dack: got first DAck cycle %0d, expected 1..6", first);
    end
    @(posedge Clock); #1;
    req[1] = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    vectors++;
    if (dut.wait_cnt_q !== 3'd0) begin
      miscompares++; $display("FAIL starve_wait_clear: got %0d, expected 0", dut.wait_cnt_q);
    end
    req = 2'b00;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic test_interleave();
    logic [1:0] exp;
    we = 2'b00; size[0] = 2'd2; size[1] = 2'd2;
    addr[0] = 32'h10; addr[1] = 32'h20;
    req = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clock); #1;
      exp = (c % 2 == 1) ? 2'b01 : 2'b10;
      vectors++;
      if (ack !== exp) begin
        miscompares++; $display("FAIL interleave_c%0d: got ack=%b, expected %b", c, ack, exp);
      end
    end
    req = 2'b00;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset_mid_store();
    logic g, e, mw; logic [31:0] rd; logic [3:0] be;
    access(0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h1122_3344, g, e, rd, mw, be);
    we[1] = 1'b1; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h80; wdata[1] = 32'hDEAD_BEEF;
    req[1] = 1'b1;
    @(posedge Clock); #1;
    vectors++;
    if (MemWrite !== 1'b1 || MAddr !== 32'h80) begin
      miscompares++; $display("FAIL rst_mid_slot: got mw=%b addr=%h, expected 1/80", MemWrite, MAddr);
    end
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if (MemWrite !== 1'b0 || ack !== 2'b00) begin
      miscompares++; $display("FAIL rst_mid_drop: got mw=%b ack=%b, expected 0/00", MemWrite, ack);
    end
    req[1] = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    vectors++;
    if (ack !== 2'b00) begin
      miscompares++; $display("FAIL rst_mid_no_ack: got ack=%b, expected 00", ack);
    end
    access(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, g, e, rd, mw, be);
    vectors++;
    if (rd !== 32'h1122_3344) begin
      miscompares++; $display("FAIL rst_mid_mem: got %h, expected 11223344", rd);
    end
  endtask

  task automatic drive_port(input int p, input int n);
    logic w, u, got, mis;
    logic [1:0] sz;
    logic [31:0] a, wd, pc, exp_rd;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clock); #1;
        vectors++;
        if (ack[p] !== 1'b0) begin
          miscompares++; $display("FAIL rand_spurious_ack_p%0d: got 1, expected 0", p);
        end
      end
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      pc = $urandom;
      we[p] = w; uns[p] = u; size[p] = sz; addr[p] = a; wdata[p] = wd;
      if (p == 0) cpc = pc;
      req[p] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(posedge Clock); #1;
        if (ack[p]) got = 1'b1;
      end
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL rand_timeout_p%0d: got no Ack, expected Ack", p);
        req[p] = 1'b0;
        continue;
      end
      mis = is_mis(sz, a);
      exp_rd = (w || mis) ? 32'd0 : ref_load(sz, u, a);
      if (w && !mis) ref_store(sz, a, wd);
      vectors++;
      if (err[p] !== mis) begin
        miscompares++; $display("FAIL rand_err_p%0d: got %b, expected %b", p, err[p], mis);
      end
      vectors++;
      if (rdata[p] !== exp_rd) begin
        miscompares++; $display("FAIL rand_rdata_p%0d: got %h, expected %h", p, rdata[p], exp_rd);
      end
      vectors++;
      if (MemWrite !== (w & ~mis) || BE !== exp_be(sz, a)) begin
        miscompares++; $display("FAIL rand_strobe_p%0d: got mw=%b be=%b, expected mw=%b be=%b",
                                p, MemWrite, BE, w & ~mis, exp_be(sz, a));
      end
      vectors++;
      if (MAddr !== a || MPc !== ((p == 0) ? pc : 32'd0)) begin
        miscompares++; $display("FAIL rand_addr_p%0d: got addr=%h pc=%h, expected addr=%h pc=%h",
                                p, MAddr, MPc, a, (p == 0) ? pc : 32'd0);
      end
      if (w && !mis) begin
        vectors++;
        if (MWData !== wd) begin
          miscompares++; $display("FAIL rand_wdata_p%0d: got %h, expected %h", p, MWData, wd);
        end
      end
      @(posedge Clock); #1;
      vectors++;
      if (ack[p] !== 1'b0) begin
        miscompares++; $display("FAIL rand_double_ack_p%0d: got 1, expected 0", p);
      end
      req[p] = 1'b0;
    end
  endtask

  task automatic test_random();
    logic g, e, mw; logic [31:0] rd, v; logic [3:0] be;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      access(1, 1'b1, 2'd2, 1'b0, 32'(4 * i), v, g, e, rd, mw, be);
      ref_store(2'd2, 32'(4 * i), v);
    end
    fork
      drive_port(0, 60);
      drive_port(1, 60);
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0;
    req = 2'b00; we = 2'b00; uns = 2'b00; cpc = '0;
    for (int i = 0; i < 2; i++) begin
      size[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
    end
    @(posedge Clock); #1;
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_starvation();
    test_interleave();
    test_reset_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory between two requesters: the CPU MEM stage (port 0) and a DMA/debug loader (port 1). Accepts sized load/store requests, registers one winner per cycle, and drives the memory's write-enable, byte-enable, address and data. It returns the size-extracted load data with a one-cycle Ack handshake. CPU has fixed priority, bounded by a starvation counter that guarantees DMA progress.

## Interface
- STARVE_LIMIT, 4: consecutive cycles DMA may wait while requesting before it is forced to win.
- Clock  in  1  system clock, all state on posedge.
- Reset  in  1  asynchronous, active-low; clears all state.
- CReq / DReq  in  1  request valid; held with its fields stable until the matching Ack.
- CWe / DWe  in  1  1 = store, 0 = load.
- CSize / DSize  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- CUns / DUns  in  1  load zero-extends when 1, sign-extends when 0.
- CAddr / DAddr  in  32  byte address.
- CWData / DWData  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- CPc  in  32  CPU instruction address, forwarded for store logging.
- CAck / DAck  out  1  one-cycle completion pulse.
- CErr / DErr  out  1  valid with Ack; misaligned access, no memory write performed.
- CRData / DRData  out  32  extended load data, valid with Ack; 0 for stores and errors.
- MemWrite  out  1  memory write strobe.
- BE  out  4  memory byte enables.
- MAddr  out  32  memory address.
- MWData  out  32  memory write data, low-aligned as received.
- MPc  out  32  CPc when the CPU owns the slot, else 0.
- MRData  in  32  combinational word read from memory at MAddr.

## Operation
- Single issue slot: valid, owner, we, size, uns, addr[1:0], BE, err, plus address, data and pc registers.
- Arbitration each cycle is over requesters with Req=1 that are not being Acked in the same cycle.
  - Default winner is CPU.
  - DMA wins if it is the only eligible requester, or if wait_cnt == STARVE_LIMIT.
- wait_cnt (3 bits, saturating at STARVE_LIMIT):
  - increments when DReq=1, DMA is eligible and DMA loses;
  - clears when DMA wins or DReq=0.
- Winner is latched into the slot at posedge; the slot is empty if there is no winner.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Violation sets err, BE=0000, MemWrite=0.
- BE:
  - byte: 0001 shifted left by addr[1:0];
  - half: 0011 at addr[1]=0, 1100 at addr[1]=1;
  - word: 1111.
- MemWrite = valid & we & ~err.
- MAddr = slot address.
- Load extract from MRData:
  - byte lane = addr[1:0];
  - half lane = addr[1];
  - extend per uns.

## Timing
- Request seen at edge t is granted there; Ack, RData and the memory drive occur in cycle t+1; store commits at edge t+2.
- Back-to-back: one access per cycle sustained. A requester being Acked is excluded from arbitration that cycle, so its next request is accepted at the following edge (2-cycle cadence per requester, interleaved 1/cycle across both).
- Ack is exactly one cycle per accepted request; never two Acks for the same requester in consecutive cycles.
- Reset reset values: slot invalid, all Ack/Err 0, MemWrite 0, BE 0000, MAddr/MWData/MPc 0, RData 0, wait_cnt 0.
- Reset asserted mid-access: the in-flight store is dropped and no Ack is issued; requesters re-present after reset.
- Both requesters with identical addresses are serialized in grant order; there is no forwarding.

## Structure
- Package dm_arb_pkg:
  - size codes SZ_BYTE / SZ_HALF / SZ_WORD;
  - owner IDs OWN_CPU=0 / OWN_DMA=1;
  - BE constants.
- Sub-module dm_load_extend: combinational, takes (MRData, size, addr[1:0], uns) and returns the 32-bit extended result.
- Arbitration, slot registers and starvation counter stay in dm_arbiter.

## Test plan
- CPU store word 0x12345678 to 0x10 -> BE=1111, MemWrite in cycle t+1, CAck, CErr=0; then a load returns 0x12345678.
- CPU store byte 0xAB to 0x13, then load byte signed -> BE=1000; CRData=0xFFFFFFAB, and 0x000000AB with CUns=1.
- CPU half store to 0x21 -> CAck with CErr=1, MemWrite stays 0, memory unchanged.
- CReq held continuously with DReq=1 and STARVE_LIMIT=4 -> DAck no later than the 6th cycle; wait_cnt returns to 0 afterwards.
- Both requesters alternating -> one Ack every cycle, CAck and DAck interleaved.
- Reset driven low in the cycle a DMA store is in the slot -> MemWrite drops immediately, no DAck, target word unchanged.
